// File: rtl/key_debouncer.sv
// Per-key debounce for active-low push buttons: two-flop synchronizer, a four-state
// qualify/hold FSM per key, and registered press/release/long-press pulses plus level.
module key_debouncer #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key_n,
  output logic [N_KEYS-1:0] o_key_pulse,
  output logic [N_KEYS-1:0] o_key_release,
  output logic [N_KEYS-1:0] o_key_level,
  output logic [N_KEYS-1:0] o_key_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {S_REL, S_PWAIT, S_PRS, S_RWAIT} state_t;

  logic [N_KEYS-1:0] sync1, sync2;

  // Synchronizer stage: resets to the released (high) pin level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= i_key_n;
      sync2 <= sync1;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    state_t          state, state_nxt;
    logic [DW-1:0]   dcnt, dcnt_nxt;
    logic [HW-1:0]   hcnt, hcnt_nxt;
    logic            p;
    logic            press_ev, rel_ev, long_ev;
    logic            pulse_q, rel_q, level_q, long_q;

    assign p = ~sync2[k];

    always_comb begin
      state_nxt = state;
      dcnt_nxt  = dcnt;
      hcnt_nxt  = hcnt;
      press_ev  = 1'b0;
      rel_ev    = 1'b0;
      long_ev   = 1'b0;
      unique case (state)
        S_REL: begin
          if (p) begin
            state_nxt = S_PWAIT;
            dcnt_nxt  = DW'(1);
          end else begin
            dcnt_nxt  = '0;
          end
        end
        S_PWAIT: begin
          if (!p) begin
            state_nxt = S_REL;
            dcnt_nxt  = '0;
          end else if (dcnt == D_MAX) begin
            state_nxt = S_PRS;
            hcnt_nxt  = '0;
            press_ev  = 1'b1;
          end else begin
            dcnt_nxt  = dcnt + DW'(1);
          end
        end
        S_PRS: begin
          if (!p) begin
            state_nxt = S_RWAIT;
            dcnt_nxt  = DW'(1);
          end else if (hcnt != H_MAX) begin
            // Saturation at H_MAX is what keeps the long event to once per press
            hcnt_nxt  = hcnt + HW'(1);
            long_ev   = (hcnt == H_LAST);
          end
        end
        S_RWAIT: begin
          if (p) begin
            state_nxt = S_PRS;
          end else if (dcnt == D_MAX) begin
            state_nxt = S_REL;
            rel_ev    = 1'b1;
          end else begin
            dcnt_nxt  = dcnt + DW'(1);
          end
        end
        default: state_nxt = S_REL;
      endcase
    end

    // FSM and registered event stage
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state   <= S_REL;
        dcnt    <= '0;
        hcnt    <= '0;
        pulse_q <= 1'b0;
        rel_q   <= 1'b0;
        level_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state   <= state_nxt;
        dcnt    <= dcnt_nxt;
        hcnt    <= hcnt_nxt;
        pulse_q <= press_ev;
        rel_q   <= rel_ev;
        level_q <= (state_nxt == S_PRS) || (state_nxt == S_RWAIT);
        long_q  <= long_ev;
      end
    end

    assign o_key_pulse[k]   = pulse_q;
    assign o_key_release[k] = rel_q;
    assign o_key_level[k]   = level_q;
    assign o_key_long[k]    = long_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_key_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_n;
  logic [2:0] pulse, rel, level, lng;

  key_debouncer #(.N_KEYS(3), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key_n      (key_n),
    .o_key_pulse  (pulse),
    .o_key_release(rel),
    .o_key_level  (level),
    .o_key_long   (lng)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] kn;
    logic [2:0] p;
    logic [2:0] r;
    logic [2:0] lv;
    logic [2:0] lg;
  } vec_t;

  vec_t       tbl [30];
  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] exp_lvl = 3'b000;

  task automatic cmp(input string name, input logic [2:0] ep, input logic [2:0] er,
                     input logic [2:0] el, input logic [2:0] eg);
    n_vec++;
    if (pulse !== ep || rel !== er || level !== el || lng !== eg) begin
      n_err++;
      $display("FAIL %s: got pulse=%b rel=%b level=%b long=%b, want pulse=%b rel=%b level=%b long=%b",
               name, pulse, rel, level, lng, ep, er, el, eg);
    end
  endtask

  // Drive kn for n edges; events expected at the given 1-based edge index (0 = none)
  task automatic hold(input string name, input logic [2:0] kn, input int n,
                      input int p_at, input logic [2:0] pm,
                      input int r_at, input logic [2:0] rm,
                      input int l_at, input logic [2:0] lm);
    logic [2:0] ep, er, eg;
    key_n = kn;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      ep = (i == p_at) ? pm : 3'b000;
      er = (i == r_at) ? rm : 3'b000;
      eg = (i == l_at) ? lm : 3'b000;
      exp_lvl = (exp_lvl | ep) & ~er;
      cmp($sformatf("%s[%0d]", name, i), ep, er, exp_lvl, eg);
    end
  endtask

  initial begin
    // Test 1 table: key0 held edges 1..20, released edges 21..30
    for (int i = 0; i < 30; i++) begin
      tbl[i].kn = (i < 20) ? 3'b110 : 3'b111;
      tbl[i].p  = (i + 1 == 7)  ? 3'b001 : 3'b000;
      tbl[i].r  = (i + 1 == 27) ? 3'b001 : 3'b000;
      tbl[i].lv = (i + 1 >= 7 && i + 1 < 27) ? 3'b001 : 3'b000;
      tbl[i].lg = (i + 1 == 17) ? 3'b001 : 3'b000;
    end

    rst   = 1'b1;
    key_n = 3'b111;
    #2;
    cmp("reset_async", 3'b000, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmp("reset_hold", 3'b000, 3'b000, 3'b000, 3'b000);
    end
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      key_n = tbl[i].kn;
      @(posedge clk); #1;
      cmp($sformatf("tbl[%0d]", i), tbl[i].p, tbl[i].r, tbl[i].lv, tbl[i].lg);
    end
    exp_lvl = 3'b000;

    // Test 2: 3-cycle press glitch, then real press
    hold("glitch_lo", 3'b110, 3, 0, 0, 0, 0, 0, 0);
    hold("glitch_hi", 3'b111, 2, 0, 0, 0, 0, 0, 0);
    hold("press",     3'b110, 7, 7, 3'b001, 0, 0, 0, 0);

    // Test 3: long press, release glitch, then real release
    hold("long",      3'b110, 12, 0, 0, 0, 0, 10, 3'b001);
    hold("rglitch_hi", 3'b111, 2, 0, 0, 0, 0, 0, 0);
    hold("rglitch_lo", 3'b110, 3, 0, 0, 0, 0, 0, 0);
    hold("held_more", 3'b110, 12, 0, 0, 0, 0, 0, 0);
    hold("release",   3'b111, 7, 0, 0, 7, 3'b001, 0, 0);

    // Test 4: keys 0 and 2 together
    hold("dual_press", 3'b010, 7, 7, 3'b101, 0, 0, 0, 0);
    hold("dual_rel",   3'b111, 7, 0, 0, 7, 3'b101, 0, 0);

    // Test 5: reset while key1 held with hcnt=5
    hold("k1_press", 3'b101, 7, 7, 3'b010, 0, 0, 0, 0);
    hold("k1_hold",  3'b101, 5, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    exp_lvl = 3'b000;
    cmp("mid_reset_async", 3'b000, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmp("mid_reset_hold", 3'b000, 3'b000, 3'b000, 3'b000);
    end
    rst = 1'b0;
    hold("k1_requal", 3'b101, 7, 7, 3'b010, 0, 0, 0, 0);
    hold("k1_rel",    3'b111, 7, 0, 0, 7, 3'b010, 0, 0);

    // Test 6: tap of exactly DEBOUNCE_CYCLES, then DEBOUNCE_CYCLES+1
    hold("tap4",      3'b110, 4, 0, 0, 0, 0, 0, 0);
    hold("tap4_idle", 3'b111, 8, 0, 0, 0, 0, 0, 0);
    hold("tap5",      3'b110, 5, 0, 0, 0, 0, 0, 0);
    hold("tap5_idle", 3'b111, 12, 2, 3'b001, 7, 3'b001, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
